psum_writeback: RTL

Drains finished output rows from the corelet's output FIFO and writes them into the partial-sum SRAM (pmem) at consecutive addresses. It sits directly downstream of the corelet:
- it consumes `ofifo_valid` / `ofifo_out`;
- it drives `ofifo_rd`;
- it generates the pmem CEN/WEN/address/data for one output tile of programmable length.

A start/busy/done handshake lets the top-level testbench or sequencer launch one tile drain at a time.

---
 rtl/psum_writeback.sv | 117 +++++++++++
 1 files changed

// File: rtl/psum_writeback.sv
// Drains finished output rows from the corelet ofifo into pmem at consecutive addresses.
// Optional build macro PSUM_WB_RELU_EN clamps negative two's-complement lanes to zero before the write.

module psum_wb_lane #(
    parameter int psum_bw = 16
) (
    input  logic [psum_bw-1:0] lane,
    output logic [psum_bw-1:0] result
);
`ifdef PSUM_WB_RELU_EN
    assign result = lane[psum_bw-1] ? '0 : lane;
`else
    assign result = lane;
`endif
endmodule

module psum_writeback #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_bw-1:0]     base_addr,
    input  logic [addr_bw-1:0]     len,
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic                   CEN_pmem,
    output logic                   WEN_pmem,
    output logic [addr_bw-1:0]     A_pmem,
    output logic [psum_bw*col-1:0] D_pmem,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, DRAIN, FIN, DONE} state_t;

    state_t                 state;
    logic [addr_bw-1:0]     base;
    logic [addr_bw-1:0]     total;
    logic [addr_bw-1:0]     cnt;
    logic [psum_bw*col-1:0] row;

    genvar g;
    generate
        for (g = 0; g < col; g++) begin : g_lane
            psum_wb_lane #(.psum_bw(psum_bw)) u_lane (
                .lane   (ofifo_out[g*psum_bw +: psum_bw]),
                .result (row[g*psum_bw +: psum_bw])
            );
        end
    endgenerate

    // Pop is combinational so a row is consumed on the same edge it is written out.
    assign ofifo_rd = !reset && (state == DRAIN) && ofifo_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base     <= '0;
            total    <= '0;
            cnt      <= '0;
            CEN_pmem <= 1'b1;
            WEN_pmem <= 1'b1;
            A_pmem   <= '0;
            D_pmem   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base  <= base_addr;
                        total <= len;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (ofifo_valid) begin
                        D_pmem   <= row;
                        A_pmem   <= base + cnt;
                        CEN_pmem <= 1'b0;
                        WEN_pmem <= 1'b0;
                        cnt      <= cnt + 1'b1;
                        if (cnt == total - 1'b1)
                            state <= FIN;
                    end else begin
                        CEN_pmem <= 1'b1;
                        WEN_pmem <= 1'b1;
                    end
                end
                FIN: begin
                    CEN_pmem <= 1'b1;
                    WEN_pmem <= 1'b1;
                    state    <= DONE;
                    done     <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
